// File: rtl/card_deck_engine.sv
// Card stack with standard-deck preload, LFSR-driven in-place Fisher-Yates shuffle,
// multi-card draw streaming and single-card insert (LIFO: top of deck is entry count-1).
module card_deck_engine #(
  parameter int CARD_W   = 6,
  parameter int DEPTH    = 128,
  parameter int IDX_W    = 7,
  parameter int LFSR_W   = 16,
  parameter int MAX_DRAW = 4,
  parameter int LOW_MARK = 4,
  parameter int LOAD_STD = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_shuffle,
  input  logic              i_clear,
  input  logic              i_draw_valid,
  input  logic [2:0]        i_draw_num,
  output logic              o_draw_ready,
  output logic [CARD_W-1:0] o_card,
  output logic              o_card_valid,
  output logic              o_card_last,
  output logic              o_draw_err,
  input  logic              i_ins_valid,
  input  logic [CARD_W-1:0] i_ins_card,
  output logic              o_ins_ready,
  output logic [IDX_W:0]    o_count,
  output logic              o_empty,
  output logic              o_low,
  output logic              o_busy,
  output logic              o_shuffle_done
);

  localparam int                STD_CARDS  = 108;
  localparam logic [IDX_W-1:0]  INIT_LAST  = IDX_W'(STD_CARDS - 1);
  localparam logic [IDX_W:0]    STD_COUNT  = (IDX_W+1)'(STD_CARDS);
  localparam logic [IDX_W:0]    DEPTH_L    = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]    LOW_L      = (IDX_W+1)'(LOW_MARK);
  localparam logic [2:0]        MAX_DRAW_L = 3'(MAX_DRAW);
  // Right-shifting Galois taps for maximal-length sequences
  localparam logic [LFSR_W-1:0] TAPS =
      (LFSR_W == 8)  ? LFSR_W'(8'hB8) :
      (LFSR_W == 24) ? LFSR_W'(24'hE10000) :
      (LFSR_W == 32) ? LFSR_W'(32'hA3000000) : LFSR_W'(16'hB400);

  typedef enum logic [1:0] {S_INIT, S_READY, S_SHUFFLE, S_DRAW} state_t;

  state_t            r_state, w_state_next;
  logic [CARD_W-1:0] r_deck [DEPTH];
  logic [IDX_W:0]    r_count;
  logic [IDX_W-1:0]  r_init_idx;
  logic [1:0]        r_init_c;
  logic [4:0]        r_init_m;
  logic [LFSR_W-1:0] r_lfsr;
  logic [IDX_W-1:0]  r_j;
  logic [2:0]        r_remain;

  logic              w_ready, w_clear_acc, w_shuf_acc, w_draw_acc, w_draw_bad, w_ins_acc;
  logic              w_init_last, w_hit;
  logic [4:0]        w_m_inc;
  logic [3:0]        w_init_value;
  logic [CARD_W-1:0] w_init_card;
  logic [IDX_W-1:0]  w_r, w_top_idx;
  logic [IDX_W:0]    w_num_ext;
  logic [LFSR_W-1:0] w_lfsr_next;

  assign w_ready     = (r_state == S_READY);
  assign w_clear_acc = w_ready && i_clear;
  assign w_shuf_acc  = w_ready && !i_clear && i_shuffle;
  assign w_draw_acc  = w_ready && !i_clear && !i_shuffle && i_draw_valid;
  assign w_num_ext   = {{(IDX_W-2){1'b0}}, i_draw_num};
  assign w_draw_bad  = (i_draw_num == 3'd0) || (i_draw_num > MAX_DRAW_L) || (w_num_ext > r_count);
  assign w_ins_acc   = i_ins_valid && o_ins_ready;
  assign w_top_idx   = IDX_W'(r_count - 1'b1);

  assign w_init_last = (r_init_idx == INIT_LAST);
  assign w_m_inc     = r_init_m + 5'd1;
  always_comb begin
    if (r_init_m == 5'd0)       w_init_value = 4'd0;
    else if (r_init_m <= 5'd24) w_init_value = w_m_inc[4:1];
    else if (r_init_m == 5'd25) w_init_value = 4'd13;
    else                        w_init_value = 4'd14;
  end
  assign w_init_card = CARD_W'({r_init_c, w_init_value});

  assign w_r         = r_lfsr[IDX_W-1:0];
  assign w_hit       = (w_r <= r_j);
  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_INIT;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT:    if (LOAD_STD == 0 || w_init_last) w_state_next = S_READY;
      S_READY: begin
        if (w_shuf_acc)                     w_state_next = S_SHUFFLE;
        else if (w_draw_acc && !w_draw_bad) w_state_next = S_DRAW;
      end
      S_SHUFFLE: if (r_j == '0)       w_state_next = S_READY;
      S_DRAW:    if (r_remain == 3'd0) w_state_next = S_READY;
      default:   w_state_next = S_INIT;
    endcase
  end

  always_comb begin
    o_draw_ready = w_ready;
    o_ins_ready  = w_ready && (r_count < DEPTH_L) && !i_clear && !i_shuffle && !i_draw_valid;
    o_busy       = !w_ready;
    o_count      = r_count;
    o_empty      = (r_count == '0);
    o_low        = (r_count < LOW_L);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count        <= '0;
      r_init_idx     <= '0;
      r_init_c       <= '0;
      r_init_m       <= '0;
      r_lfsr         <= '0;
      r_j            <= '0;
      r_remain       <= '0;
      o_card         <= '0;
      o_card_valid   <= 1'b0;
      o_card_last    <= 1'b0;
      o_draw_err     <= 1'b0;
      o_shuffle_done <= 1'b0;
    end else begin
      o_card_valid   <= 1'b0;
      o_card_last    <= 1'b0;
      o_draw_err     <= 1'b0;
      o_shuffle_done <= 1'b0;
      case (r_state)
        S_INIT: if (LOAD_STD != 0) begin
          r_deck[r_init_idx] <= w_init_card;
          r_init_idx         <= r_init_idx + 1'b1;
          if (r_init_m == 5'd26) begin
            r_init_m <= '0;
            r_init_c <= r_init_c + 1'b1;
          end else begin
            r_init_m <= r_init_m + 5'd1;
          end
          if (w_init_last) r_count <= STD_COUNT;
        end
        S_READY: begin
          if (w_clear_acc) begin
            r_count <= '0;
          end else if (w_shuf_acc) begin
            r_lfsr <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
            r_j    <= (r_count <= 1) ? '0 : IDX_W'(r_count - 1'b1);
          end else if (w_draw_acc) begin
            if (w_draw_bad) begin
              o_draw_err <= 1'b1;
            end else begin
              // First card leaves on the accept edge so cards appear in T+1..T+N
              o_card       <= r_deck[w_top_idx];
              o_card_valid <= 1'b1;
              o_card_last  <= (i_draw_num == 3'd1);
              r_count      <= r_count - 1'b1;
              r_remain     <= i_draw_num - 3'd1;
            end
          end else if (w_ins_acc) begin
            r_deck[r_count[IDX_W-1:0]] <= i_ins_card;
            r_count                    <= r_count + 1'b1;
          end
        end
        S_SHUFFLE: begin
          r_lfsr <= w_lfsr_next;
          if (r_j == '0) begin
            o_shuffle_done <= 1'b1;
          end else if (w_hit) begin
            r_deck[r_j] <= r_deck[w_r];
            r_deck[w_r] <= r_deck[r_j];
            r_j         <= r_j - 1'b1;
          end
        end
        S_DRAW: if (r_remain != 3'd0) begin
          o_card       <= r_deck[w_top_idx];
          o_card_valid <= 1'b1;
          o_card_last  <= (r_remain == 3'd1);
          r_count      <= r_count - 1'b1;
          r_remain     <= r_remain - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/card_deck_engine.md
Name: card_deck_engine

Overview:
Parametrised successor to the UNO deck store. It holds up to DEPTH cards as a stack. It fills the standard 108-card layout after reset, shuffles the held cards in place with a Fisher-Yates pass driven by an LFSR, and streams 1..MAX_DRAW cards per draw request through a valid/ready handshake. It also accepts returned cards, for example the discard pile during a refill, and sits between the game-control FSM and the hand/discard logic.

Parameters:
CARD_W, 6, card width as {color[1:0], value[3:0]}; must be >= 6, with upper bits zero-filled.
DEPTH, 128, storage entries; must be >= 108 when LOAD_STD=1.
IDX_W, 7, index width; must satisfy 2**IDX_W >= DEPTH.
LFSR_W, 16, shuffle LFSR width.
MAX_DRAW, 4, largest cards per draw request (<= 7).
LOW_MARK, 4, count threshold for o_low.
LOAD_STD, 1, 1 = load the standard deck after reset; 0 = start empty.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_seed  in  LFSR_W  shuffle seed, sampled when i_shuffle is accepted
i_shuffle  in  1  shuffle command (single-cycle pulse)
i_clear  in  1  discard all cards (single-cycle pulse)
i_draw_valid  in  1  draw request valid
i_draw_num  in  3  cards requested
o_draw_ready  out  1  draw request can be accepted
o_card  out  CARD_W  drawn card
o_card_valid  out  1  o_card is valid this cycle
o_card_last  out  1  final card of the current request
o_draw_err  out  1  1-cycle pulse: request rejected
i_ins_valid  in  1  insert valid
i_ins_card  in  CARD_W  card to insert
o_ins_ready  out  1  insert can be accepted
o_count  out  IDX_W+1  cards held
o_empty  out  1  o_count == 0
o_low  out  1  o_count < LOW_MARK
o_busy  out  1  state != READY
o_shuffle_done  out  1  1-cycle pulse when a shuffle completes

Behaviour:
- Reset: every registered output is 0, count = 0, state = INIT. A reset mid-operation abandons the operation with no partial outputs afterwards.
- States: INIT, READY, SHUFFLE, DRAW.
- INIT:
  - With LOAD_STD=1, writes entry k each cycle for k = 0..107, then count = 108 and the block enters READY. Total 108 cycles.
  - Entry k: c = k/27, m = k%27. value = 0 if m=0; (m+1)/2 if 1<=m<=24; 13 if m=25; 14 if m=26. card = {c, value}.
  - With LOAD_STD=0, the block goes to READY on the next cycle with count = 0.
- READY command priority: i_clear > i_shuffle > draw > insert.
  - o_draw_ready = (state==READY).
  - o_ins_ready = (state==READY) && count<DEPTH && !i_clear && !i_shuffle && !i_draw_valid.
  - i_clear: count <= 0, state stays READY.
- Insert (i_ins_valid && o_ins_ready): deck[count] <= i_ins_card and count++. There is one insert per cycle.
- Draw request accepted in cycle T:
  - If i_draw_num == 0, i_draw_num > MAX_DRAW, or i_draw_num > count: o_draw_err pulses in T+1, no cards are output, and the block stays in READY.
  - Otherwise it enters DRAW. In cycles T+1..T+N it outputs o_card = deck[count-1] with o_card_valid = 1, then count--.
  - o_card_last is asserted with the Nth card. READY is re-entered at T+N+1.
- Shuffle accepted in cycle T:
  - lfsr <= (i_seed == 0) ? 1 : i_seed; j <= count-1. The block enters SHUFFLE.
  - Each SHUFFLE cycle: r = lfsr[IDX_W-1:0]. If r <= j, swap deck[j] and deck[r], then j--; otherwise reject (no swap). lfsr advances every cycle.
  - LFSR is Galois, right-shift: if lsb = 1, next = (lfsr>>1) ^ 16'hB400; else next = lfsr>>1. For other LFSR_W values, use a maximal-length tap constant.
  - The shuffle ends in the cycle after j reaches 0: o_shuffle_done pulses and the block returns to READY. If count <= 1, it returns on T+2 with o_shuffle_done pulsed.
  - The multiset of cards and count are unchanged by a shuffle.
- i_shuffle, i_clear, draws and inserts are ignored outside READY.
- o_count, o_empty and o_low are updated combinationally from the count register.

Test Plan:
- Reset with LOAD_STD=1: o_busy is high for 108 cycles, then o_count = 108. Draw 4 from the unshuffled deck -> cards 6'h3E, 3D, 3C, 3C on consecutive cycles with o_card_last on the 4th, and o_count = 104.
- Shuffle with i_seed = 16'h0000 -> LFSR loads 1. o_shuffle_done fires once, o_count = 108, and a full drain of 108 cards shows the same per-value histogram as the standard deck.
- Draw num = 3 with count = 2 -> o_draw_err pulse, no o_card_valid, count stays 2. Draw num = 0 and num = 5 -> o_draw_err.
- Clear, then insert 6'h05, 6'h2A, 6'h13 -> count = 3. Draw 3 -> 13, 2A, 05 (LIFO).
- i_draw_valid and i_ins_valid in the same READY cycle -> the draw is accepted and o_ins_ready = 0. Fill to DEPTH = 128 -> o_ins_ready = 0 and count holds at 128.
- Assert i_rst during the 2nd card of a draw 4 -> o_card_valid is low from the next cycle, INIT restarts, and o_count = 108 afterward.
